// File: rtl/clk_mon_pkg.sv
// Shared definitions for the slow-clock monitor: FSM state encoding and
// default synchronizer depth.
package clk_mon_pkg;

    // Monitor state encoding; values are fixed so they can be observed externally.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_e;

    // Default number of synchronizer flops on the asynchronous slow clock.
    localparam int DEF_SYNC_STAGES = 2;

endpackage : clk_mon_pkg

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous slow clock into the system clock domain and
// produces registered one-cycle rise/fall strobes. The synchronizer chain and
// the history flop keep running while disabled, so re-enabling with the slow
// clock already high does not fabricate a rising edge.
module sync_edge_detect
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic slow_clk,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain plus edge-history flop; free-running regardless of enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], slow_clk};
            hist_r <= sync_s;
        end
    end

    // Registered edge strobes, forced low while the monitor is disabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else if (!enable) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= sync_s & ~hist_r;
            fall_r <= ~sync_s & hist_r;
        end
    end

    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;

endmodule : sync_edge_detect

// File: rtl/clock_edge_monitor.sv
// Slow-clock receiver: edge strobes usable as clock enables, rise-to-rise
// period measurement in system clocks, lock tracking and loss-of-clock flag.
module clock_edge_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             slow_clk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);

    state_e             state_r;
    state_e             state_nx;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   period_r;
    logic [CNT_W-1:0]   period_nx;
    logic               pv_r;
    logic               pv_nx;
    logic               locked_r;
    logic               lost_r;
    logic               rise_s;
    logic               fall_s;
    logic               timeout_s;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .slow_clk   (slow_clk),
        .rise_pulse (rise_s),
        .fall_pulse (fall_s)
    );

    assign timeout_s = (cnt_r >= CNT_TMO);

    // Period counter: restarts at 1 on each rise, saturates instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (!enable) begin
            cnt_r <= '0;
        end else if (rise_s) begin
            cnt_r <= CNT_ONE;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state and period-capture decode; a rise beats a coincident timeout.
    always_comb begin
        state_nx  = state_r;
        period_nx = period_r;
        pv_nx     = 1'b0;
        if (!enable) begin
            state_nx  = ST_IDLE;
            period_nx = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_nx = ST_ARMED;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_ARMED, ST_LOCKED: begin
                    if (rise_s) begin
                        state_nx  = ST_LOCKED;
                        period_nx = cnt_r;
                        pv_nx     = 1'b1;
                    end else if (timeout_s) begin
                        state_nx = ST_LOST;
                    end else begin
                        state_nx = state_r;
                    end
                end
                ST_LOST: begin
                    if (rise_s) begin
                        state_nx = ST_ARMED;
                    end else begin
                        state_nx = ST_LOST;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State, period register and status flags, all registered together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            period_r <= '0;
            pv_r     <= 1'b0;
            locked_r <= 1'b0;
            lost_r   <= 1'b0;
        end else begin
            state_r  <= state_nx;
            period_r <= period_nx;
            pv_r     <= pv_nx;
            locked_r <= (state_nx == ST_LOCKED);
            lost_r   <= (state_nx == ST_LOST);
        end
    end

    assign rise_pulse   = rise_s;
    assign fall_pulse   = fall_s;
    assign period_out   = period_r;
    assign period_valid = pv_r;
    assign locked       = locked_r;
    assign lost         = lost_r;

endmodule : clock_edge_monitor

// File: tb/tb_clock_edge_monitor.sv
// Directed bench for clock_edge_monitor with SYNC_STAGES=2, CNT_W=8, TIMEOUT=20.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_clock_edge_monitor;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int TIMEOUT     = 20;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b1;
    logic             slow_clk = 1'b0;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             lost;

    int vec_cnt = 0;
    int err_cnt = 0;

    clock_edge_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .slow_clk     (slow_clk),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period_out   (period_out),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    // System clock, period 10.
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rise"}, 32'(rise_pulse), 32'd0);
        chk({tag, ".fall"}, 32'(fall_pulse), 32'd0);
        chk({tag, ".pv"}, 32'(period_valid), 32'd0);
        chk({tag, ".per"}, 32'(period_out), 32'd0);
        chk({tag, ".lock"}, 32'(locked), 32'd0);
        chk({tag, ".lost"}, 32'(lost), 32'd0);
    endtask

    // n slow-clock periods of 3 high / 3 low starting from IDLE with slow_clk
    // settled low and period_out==0. Rise lands 3 ticks after the 0->1 drive.
    task automatic run_periods(input string tag, input int n);
        bit lk;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 6; j++) begin
                slow_clk = (j < 3);
                tick();
                lk = (k >= 2) || (k == 1 && j >= 3);
                chk({tag, ".rise"}, 32'(rise_pulse), 32'(j == 2));
                chk({tag, ".fall"}, 32'(fall_pulse), 32'(j == 5));
                chk({tag, ".pv"}, 32'(period_valid), 32'(j == 3 && k >= 1));
                chk({tag, ".lock"}, 32'(locked), 32'(lk));
                chk({tag, ".per"}, 32'(period_out), lk ? 32'd6 : 32'd0);
                chk({tag, ".lost"}, 32'(lost), 32'd0);
            end
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b0; enable = 1'b1; slow_clk = 1'b0;
        tick(); tick(); tick();
        chk_zero("rst");
        reset = 1'b1;
        tick(); tick();

        // Single 0->1 then 1->0: strobes SYNC_STAGES+1 clocks after the change
        slow_clk = 1'b1;
        tick(); chk("lat.rise0", 32'(rise_pulse), 32'd0);
        tick(); chk("lat.rise1", 32'(rise_pulse), 32'd0);
        tick(); chk("lat.rise2", 32'(rise_pulse), 32'd1);
        tick(); chk("lat.rise3", 32'(rise_pulse), 32'd0);
        chk("lat.armed_lock", 32'(locked), 32'd0);
        slow_clk = 1'b0;
        tick(); chk("lat.fall0", 32'(fall_pulse), 32'd0);
        tick(); chk("lat.fall1", 32'(fall_pulse), 32'd0);
        tick(); chk("lat.fall2", 32'(fall_pulse), 32'd1);
        tick(); chk("lat.fall3", 32'(fall_pulse), 32'd0);

        // Back to IDLE, then period-6 slow clock
        enable = 1'b0;
        tick(); chk_zero("dis0");
        enable = 1'b1;
        run_periods("p6", 4);

        // Slow clock stops high: one more rise, then LOST when cnt hits 20
        for (int i = 0; i < 26; i++) begin
            slow_clk = 1'b1;
            tick();
            if (i == 2)  chk("stop.rise", 32'(rise_pulse), 32'd1);
            if (i == 3)  chk("stop.pv", 32'(period_valid), 32'd1);
            if (i == 22) chk("stop.cnt", 32'(dut.cnt_r), 32'd20);
            chk("stop.lost", 32'(lost), 32'(i >= 23));
            chk("stop.lock", 32'(locked), 32'(i < 23));
        end
        chk("stop.per", 32'(period_out), 32'd6);

        // Restart from LOST: ARMED on first rise, LOCKED on the next
        slow_clk = 1'b0;
        repeat (5) tick();
        slow_clk = 1'b1;
        repeat (3) tick();
        chk("rs.rise", 32'(rise_pulse), 32'd1);
        chk("rs.lost_hold", 32'(lost), 32'd1);
        chk("rs.per_hold", 32'(period_out), 32'd6);
        tick();
        chk("rs.lost_clr", 32'(lost), 32'd0);
        chk("rs.armed", 32'(locked), 32'd0);
        repeat (2) tick();
        slow_clk = 1'b0;
        repeat (3) tick();
        slow_clk = 1'b1;
        repeat (3) tick();
        chk("rs.rise2", 32'(rise_pulse), 32'd1);
        chk("rs.not_yet", 32'(locked), 32'd0);
        tick();
        chk("rs.lock", 32'(locked), 32'd1);
        chk("rs.pv", 32'(period_valid), 32'd1);
        chk("rs.per", 32'(period_out), 32'd9);

        // Rise coinciding with cnt==TIMEOUT: rise wins
        slow_clk = 1'b0;
        repeat (16) tick();
        slow_clk = 1'b1;
        repeat (3) tick();
        chk("tmo.rise", 32'(rise_pulse), 32'd1);
        chk("tmo.cnt", 32'(dut.cnt_r), 32'd20);
        tick();
        chk("tmo.lock", 32'(locked), 32'd1);
        chk("tmo.lost", 32'(lost), 32'd0);
        chk("tmo.pv", 32'(period_valid), 32'd1);
        chk("tmo.per", 32'(period_out), 32'd20);

        // Enable dropped mid-LOCKED; re-enable with slow_clk high gives no rise
        enable = 1'b0;
        tick(); chk_zero("dis1");
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); chk("reen.norise", 32'(rise_pulse), 32'd0);
        end
        slow_clk = 1'b0;
        repeat (5) tick();
        run_periods("p6b", 3);

        // Asynchronous reset mid-period, then two rises needed to lock again
        #2 reset = 1'b0;
        #1 chk_zero("arst");
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        run_periods("p6c", 3);

        // Long idle without edges: counter saturates at 255, no LOST in IDLE
        enable = 1'b0;
        tick();
        enable = 1'b1;
        for (int i = 1; i <= 266; i++) begin
            tick();
            if (i == 100) chk("sat.c100", 32'(dut.cnt_r), 32'd100);
            if (i == 255) chk("sat.c255", 32'(dut.cnt_r), 32'd255);
        end
        chk("sat.cnt", 32'(dut.cnt_r), 32'd255);
        chk("sat.lost", 32'(lost), 32'd0);
        chk("sat.lock", 32'(locked), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_clock_edge_monitor
